// File: rtl/gshare_btb_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor: PHT counter encodings
// and the prediction-mode selector values.
package gshare_btb_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int PRED_STATIC  = 0;
    localparam int PRED_BIMODAL = 1;
    localparam int PRED_GSHARE  = 2;

endpackage

// File: rtl/gshare_btb_predictor_sat_counter2.sv
// Two-bit saturating counter update used on every PHT training write.
module sat_counter2
    import gshare_btb_predictor_pkg::*;
(
    input  logic [1:0] count,
    input  logic       up,
    output logic [1:0] count_next
);

    always_comb begin
        count_next = count;
        if (up) begin
            if (count != ST) count_next = count + 2'd1;
        end else begin
            if (count != SNT) count_next = count - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Fetch-stage branch predictor: static/bimodal/gshare PHT, tagged direct-mapped
// BTB, speculative global history with repair from execute.
module gshare_btb_predictor
    import gshare_btb_predictor_pkg::*;
#(
    parameter int N         = 12,
    parameter int BTB_BITS  = 6,
    parameter int PRED_MODE = 2
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          f_fire,
    input  logic [31:0]   f_pc,
    output logic          pred_hit,
    output logic          pred_taken,
    output logic [31:0]   pred_target,
    output logic [N-1:0]  pred_history,
    input  logic          e_valid,
    input  logic          e_is_jump_instr,
    input  logic [31:0]   e_pc,
    input  logic          fact_taken,
    input  logic [31:0]   fact_pc,
    input  logic          fact_success,
    input  logic [N-1:0]  train_history,
    output logic [31:0]   branch_cnt,
    output logic [31:0]   mispred_cnt
);

    localparam int PHT_SIZE = 1 << N;
    localparam int BTB_SIZE = 1 << BTB_BITS;
    localparam int TAG_W    = 30 - BTB_BITS;

    // PHT kept as one packed vector so the whole table resets in one assignment.
    logic [2*PHT_SIZE-1:0] pht;
    logic [BTB_SIZE-1:0]   btb_valid;
    logic [TAG_W-1:0]      btb_tag    [BTB_SIZE];
    logic [31:0]           btb_target [BTB_SIZE];
    logic [N-1:0]          ghr;

    logic [BTB_BITS-1:0] f_idx;
    logic [BTB_BITS-1:0] e_idx;
    logic [TAG_W-1:0]    f_tag;
    logic [TAG_W-1:0]    e_tag;
    logic [N-1:0]        f_pidx;
    logic [N-1:0]        e_pidx;
    logic [1:0]          e_count;
    logic [1:0]          e_count_next;
    logic                train;
    logic                unused_pc_bits;

    assign f_idx = f_pc[BTB_BITS+1:2];
    assign f_tag = f_pc[31:BTB_BITS+2];
    assign e_idx = e_pc[BTB_BITS+1:2];
    assign e_tag = e_pc[31:BTB_BITS+2];
    assign unused_pc_bits = ^{f_pc[1:0], e_pc[1:0]};

    // Training hashes with the history the instruction was predicted under.
    assign f_pidx = (PRED_MODE == PRED_GSHARE) ? (f_pc[N+1:2] ^ ghr)           : f_pc[N+1:2];
    assign e_pidx = (PRED_MODE == PRED_GSHARE) ? (e_pc[N+1:2] ^ train_history) : e_pc[N+1:2];

    assign train = e_valid & e_is_jump_instr;

    assign pred_hit     = btb_valid[f_idx] & (btb_tag[f_idx] == f_tag);
    assign pred_taken   = (PRED_MODE == PRED_STATIC) ? 1'b0 : (pred_hit & pht[{f_pidx, 1'b1}]);
    assign pred_target  = pred_taken ? btb_target[f_idx] : (f_pc + 32'd4);
    assign pred_history = ghr;

    assign e_count = pht[{e_pidx, 1'b0} +: 2];

    sat_counter2 u_sat (
        .count      (e_count),
        .up         (fact_taken),
        .count_next (e_count_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pht <= {PHT_SIZE{WNT}};
        end else if (train) begin
            pht[{e_pidx, 1'b0} +: 2] <= e_count_next;
        end
    end

    // Tag/target payload needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (train && fact_taken) begin
            btb_tag[e_idx]    <= e_tag;
            btb_target[e_idx] <= fact_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_valid <= '0;
        end else if (train && fact_taken) begin
            btb_valid[e_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (train) begin
            if (branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
            if (!fact_success && (mispred_cnt != 32'hFFFF_FFFF)) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    // Repair from execute outranks the speculative shift from fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (train && !fact_success) begin
            ghr <= {train_history[N-2:0], fact_taken};
        end else if (f_fire && pred_hit) begin
            ghr <= {ghr[N-2:0], pred_taken};
        end
    end

endmodule
